// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the I/D memory-port arbiter.
// State encoding, bus-error read value and byte-enable width helper.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    // Read data returned to a requester whose access timed out.
    localparam int BUS_ERR_RDATA = 0;

    function automatic int be_width(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester and memory-side signals of the arbiter.
// slave = arbiter view, master = datapath/memory environment view.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    logic              i_stall;

    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_be;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_ready;
    logic                d_stall;

    logic bus_err;

    logic                m_req;
    logic                m_we;
    logic [DATA_W/8-1:0] m_be;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W-1:0]   m_rdata;
    logic                m_ack;

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        input  m_rdata, m_ack,
        output i_rdata, i_ready, i_stall,
        output d_rdata, d_ready, d_stall,
        output bus_err,
        output m_req, m_we, m_be, m_addr, m_wdata
    );

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        output m_rdata, m_ack,
        input  i_rdata, i_ready, i_stall,
        input  d_rdata, d_ready, d_stall,
        input  bus_err,
        input  m_req, m_we, m_be, m_addr, m_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_timeout_cnt.sv
// Bus-access watchdog: counts BUSY cycles, flags the last allowed one.
// TIMEOUT=0 keeps expired permanently low.
module arb_timeout_cnt #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear between accesses, advance while busy.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // High in the TIMEOUT-th busy cycle, so BUSY lasts at most TIMEOUT cycles.
    assign expired = (TIMEOUT != 0) && en && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates fetch (I) and load/store (D) onto one memory port.
// D has priority; a starvation counter forces I after MAX_WAIT D grants.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int TIMEOUT  = 255
) (
    input logic         clk,
    input logic         rstn,
    mem_bus_arbiter_if.slave bus
);

    localparam int BE_W = be_width(DATA_W);
    localparam int SW   = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [SW-1:0]     STARVE_MAX = SW'(MAX_WAIT);
    localparam logic [DATA_W-1:0] ERR_RDATA  = DATA_W'(BUS_ERR_RDATA);

    arb_state_e state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;

    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [BE_W-1:0]   m_be_q, m_be_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;

    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              bus_err_q, bus_err_d;

    logic grant_d;
    logic grant_i;
    logic to_clr;
    logic to_en;
    logic to_expired;

    assign grant_d = bus.d_req && !(bus.i_req && (starve_q == STARVE_MAX));
    assign grant_i = bus.i_req && !grant_d;

    arb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_to (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (to_clr),
        .en      (to_en),
        .expired (to_expired)
    );

    // Next-state, grant capture and completion logic.
    always_comb begin
        state_d   = state_q;
        starve_d  = starve_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_be_d    = m_be_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = 1'b0;
        d_ready_d = 1'b0;
        bus_err_d = 1'b0;
        to_clr    = 1'b0;
        to_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                to_clr = 1'b1;
                if (grant_d) begin
                    state_d   = BUSY_D;
                    m_req_d   = 1'b1;
                    m_we_d    = bus.d_we;
                    m_be_d    = bus.d_be;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    if (!bus.i_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 1'b1;
                    end
                end else if (grant_i) begin
                    state_d  = BUSY_I;
                    m_req_d  = 1'b1;
                    m_we_d   = 1'b0;
                    m_be_d   = '1;
                    m_addr_d = bus.i_addr;
                    starve_d = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                to_en = 1'b1;
                if (bus.m_ack) begin
                    state_d = DONE;
                    m_req_d = 1'b0;
                    if (state_q == BUSY_D) begin
                        d_rdata_d = bus.m_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = bus.m_rdata;
                        i_ready_d = 1'b1;
                    end
                end else if (to_expired) begin
                    state_d   = DONE;
                    m_req_d   = 1'b0;
                    bus_err_d = 1'b1;
                    if (state_q == BUSY_D) begin
                        d_rdata_d = ERR_RDATA;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = ERR_RDATA;
                        i_ready_d = 1'b1;
                    end
                end
            end
            DONE: begin
                to_clr  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, memory-side and requester-side registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            starve_q  <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_be_q    <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_be_q    <= m_be_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_be    = m_be_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_ready = d_ready_q;
    assign bus.bus_err = bus_err_q;
    assign bus.i_stall = bus.i_req & ~i_ready_q;
    assign bus.d_stall = bus.d_req & ~d_ready_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (MAX_WAIT=4, TIMEOUT=8).
// Transaction-level reference model plus directed literal checks.
module tb_mem_bus_arbiter;

    localparam int MW = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_bus_arbiter #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .MAX_WAIT (MW),
        .TIMEOUT  (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Memory responder: ack 'lat' cycles into an access (0 = never).
    int          lat = 1;
    int          rcnt = 0;
    bit          acked = 0;
    logic        resp_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic [31:0] resp_data = 32'h0;

    assign bus.m_ack   = resp_ack | stray_ack;
    assign bus.m_rdata = resp_data;

    always @(negedge clk) begin
        if (!bus.m_req) begin
            rcnt     <= 0;
            acked    <= 0;
            resp_ack <= 1'b0;
        end else if (!acked) begin
            if (lat != 0 && rcnt + 1 == lat) begin
                resp_ack <= 1'b1;
                acked    <= 1;
            end
            rcnt <= rcnt + 1;
        end else begin
            resp_ack <= 1'b0;
        end
    end

    // Reference model: one access at a time, phases idle/busy/done.
    localparam int PH_IDLE = 0;
    localparam int PH_BUSY = 1;
    localparam int PH_DONE = 2;

    int          ph = PH_IDLE;
    bit          own_d = 0;
    int          busy_len = 0;
    int          starve = 0;
    logic        e_m_req = 0, e_m_we = 0;
    logic [3:0]  e_m_be = 0;
    logic [31:0] e_m_addr = 0, e_m_wdata = 0;
    logic [31:0] e_i_rdata = 0, e_d_rdata = 0;
    logic        e_i_ready = 0, e_d_ready = 0, e_err = 0;
    byte         glog[$];
    byte         dlog[$];

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ph <= PH_IDLE; busy_len <= 0; starve <= 0;
            e_m_req <= 0; e_m_we <= 0; e_m_be <= 0;
            e_m_addr <= 0; e_m_wdata <= 0;
            e_i_rdata <= 0; e_d_rdata <= 0;
            e_i_ready <= 0; e_d_ready <= 0; e_err <= 0;
        end else begin
            e_i_ready <= 0; e_d_ready <= 0; e_err <= 0;
            if (ph == PH_DONE) begin
                ph <= PH_IDLE;
            end else if (ph == PH_IDLE) begin
                if (bus.d_req && !(bus.i_req && starve == MW)) begin
                    glog.push_back("D");
                    ph <= PH_BUSY; own_d <= 1; busy_len <= 0;
                    e_m_req <= 1; e_m_we <= bus.d_we; e_m_be <= bus.d_be;
                    e_m_addr <= bus.d_addr; e_m_wdata <= bus.d_wdata;
                    starve <= bus.i_req ? ((starve < MW) ? starve + 1 : MW) : 0;
                end else if (bus.i_req) begin
                    glog.push_back("I");
                    ph <= PH_BUSY; own_d <= 0; busy_len <= 0;
                    e_m_req <= 1; e_m_we <= 0; e_m_be <= 4'hF;
                    e_m_addr <= bus.i_addr;
                    starve <= 0;
                end
            end else begin
                busy_len <= busy_len + 1;
                if (bus.m_ack) begin
                    ph <= PH_DONE; e_m_req <= 0;
                    if (own_d) begin
                        e_d_rdata <= bus.m_rdata; e_d_ready <= 1;
                    end else begin
                        e_i_rdata <= bus.m_rdata; e_i_ready <= 1;
                    end
                end else if (busy_len + 1 == TO) begin
                    ph <= PH_DONE; e_m_req <= 0; e_err <= 1;
                    if (own_d) begin
                        e_d_rdata <= 0; e_d_ready <= 1;
                    end else begin
                        e_i_rdata <= 0; e_i_ready <= 1;
                    end
                end
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        chk("m_req", 32'(bus.m_req), 32'(e_m_req));
        chk("m_we", 32'(bus.m_we), 32'(e_m_we));
        chk("m_be", 32'(bus.m_be), 32'(e_m_be));
        chk("m_addr", bus.m_addr, e_m_addr);
        chk("m_wdata", bus.m_wdata, e_m_wdata);
        chk("i_rdata", bus.i_rdata, e_i_rdata);
        chk("d_rdata", bus.d_rdata, e_d_rdata);
        chk("i_ready", 32'(bus.i_ready), 32'(e_i_ready));
        chk("d_ready", 32'(bus.d_ready), 32'(e_d_ready));
        chk("bus_err", 32'(bus.bus_err), 32'(e_err));
        chk("i_stall", 32'(bus.i_stall), 32'(bus.i_req & ~e_i_ready));
        chk("d_stall", 32'(bus.d_stall), 32'(bus.d_req & ~e_d_ready));
        if (rstn && bus.d_ready) dlog.push_back("D");
        if (rstn && bus.i_ready) dlog.push_back("I");
    end

    task automatic wait_rdy(input bit is_d, output int n);
        logic r;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            r = is_d ? bus.d_ready : bus.i_ready;
            if (r || n >= 50) break;
        end
        chk(is_d ? "d_ready_seen" : "i_ready_seen", 32'(r), 32'd1);
    endtask

    int n;
    byte exp_order[10];

    initial begin
        exp_order = '{"D", "D", "D", "D", "I", "D", "D", "D", "D", "I"};
        bus.i_req = 0; bus.i_addr = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_be = 0;
        bus.d_addr = 0; bus.d_wdata = 0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_m_req", 32'(bus.m_req), 0);
        chk("rst_m_addr", bus.m_addr, 0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_ready", 32'({bus.i_ready, bus.d_ready, bus.bus_err}), 0);
        #1 rstn = 1'b1;

        // Lone load
        @(negedge clk);
        lat = 3; resp_data = 32'h12345678;
        bus.d_req = 1; bus.d_addr = 32'h100; bus.d_be = 4'hF;
        @(negedge clk);
        chk("load_m_req", 32'(bus.m_req), 1);
        chk("load_m_addr", bus.m_addr, 32'h100);
        wait_rdy(1, n);
        chk("load_lat", n, 3);
        chk("load_rdata", bus.d_rdata, 32'h12345678);
        chk("load_i_ready", 32'(bus.i_ready), 0);
        bus.d_req = 0;

        // Store fields
        @(negedge clk);
        lat = 2; resp_data = 32'h0;
        bus.d_req = 1; bus.d_we = 1; bus.d_be = 4'b0011;
        bus.d_wdata = 32'hCAFEF00D; bus.d_addr = 32'h204;
        @(negedge clk);
        chk("st_m_we", 32'(bus.m_we), 1);
        chk("st_m_be", 32'(bus.m_be), 32'h3);
        chk("st_m_wdata", bus.m_wdata, 32'hCAFEF00D);
        chk("st_m_addr", bus.m_addr, 32'h204);
        wait_rdy(1, n);
        bus.d_req = 0; bus.d_we = 0;
        @(negedge clk);
        chk("st_one_pulse", 32'(bus.d_ready), 0);

        // Simultaneous requests, starvation guard
        lat = 1; resp_data = 32'h0BADF00D;
        glog.delete(); dlog.delete();
        bus.i_req = 1; bus.i_addr = 32'h80;
        bus.d_req = 1; bus.d_addr = 32'h180; bus.d_be = 4'hF;
        for (int k = 0; k < 80 && dlog.size() < 10; k++) @(negedge clk);
        bus.i_req = 0; bus.d_req = 0;
        repeat (4) @(negedge clk);
        chk("order_len", 32'(dlog.size() >= 10), 1);
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("model_order%0d", k),
                32'(k < glog.size() ? glog[k] : 0), 32'(exp_order[k]));
            chk($sformatf("dut_order%0d", k),
                32'(k < dlog.size() ? dlog[k] : 0), 32'(exp_order[k]));
        end
        chk("i_rdata_pre_to", bus.i_rdata, 32'h0BADF00D);

        // Timeout on fetch
        lat = 0;
        bus.i_req = 1; bus.i_addr = 32'h40;
        @(negedge clk);
        chk("to_m_req", 32'(bus.m_req), 1);
        wait_rdy(0, n);
        chk("to_cycles", n, TO);
        chk("to_bus_err", 32'(bus.bus_err), 1);
        chk("to_i_rdata", bus.i_rdata, 0);
        bus.i_req = 0;
        @(negedge clk);
        chk("to_err_pulse", 32'({bus.i_ready, bus.bus_err}), 0);

        // Async reset mid-access
        lat = 0;
        bus.d_req = 1; bus.d_addr = 32'h300;
        @(negedge clk);
        chk("rm_m_req", 32'(bus.m_req), 1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1 chk("rm_m_req_drop", 32'(bus.m_req), 0);
        repeat (2) begin
            @(negedge clk);
            chk("rm_no_ready", 32'(bus.d_ready), 0);
        end
        lat = 1; resp_data = 32'h55AA55AA;
        #1 rstn = 1'b1;
        @(negedge clk);
        chk("rm_regrant", 32'(bus.m_req), 1);
        chk("rm_regrant_addr", bus.m_addr, 32'h300);
        wait_rdy(1, n);
        chk("rm_rdata", bus.d_rdata, 32'h55AA55AA);
        bus.d_req = 0;

        // Stray ack in IDLE
        repeat (2) @(negedge clk);
        resp_data = 32'hDEADBEEF; stray_ack = 1;
        @(negedge clk);
        stray_ack = 0;
        chk("sa_idle_ready", 32'({bus.i_ready, bus.d_ready}), 0);
        chk("sa_idle_m_req", 32'(bus.m_req), 0);
        chk("sa_idle_d_rdata", bus.d_rdata, 32'h55AA55AA);

        // Stray ack in DONE
        @(negedge clk);
        lat = 1; resp_data = 32'h11112222;
        bus.d_req = 1; bus.d_addr = 32'h400;
        wait_rdy(1, n);
        bus.d_req = 0;
        resp_data = 32'hDEADBEEF; stray_ack = 1;
        chk("sa_done_rdata0", bus.d_rdata, 32'h11112222);
        @(negedge clk);
        stray_ack = 0;
        chk("sa_done_ready", 32'(bus.d_ready), 0);
        chk("sa_done_d_rdata", bus.d_rdata, 32'h11112222);
        @(negedge clk);
        chk("sa_done_m_req", 32'(bus.m_req), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
